// File: rtl/fifo_ptr_ctrl_pkg.sv
// fifo_ptr_ctrl_pkg
// Shared sizing constants and the pointer type for the FIFO pointer controller.
//   FIFO_DATA_W : width of each stored word
//   FIFO_ADDR_W : storage address width
//   FIFO_PTR_W  : pointer width (address plus one wrap bit)
//   FIFO_DEPTH  : number of storage slots
//   ptr_t       : pointer type of FIFO_PTR_W bits
package fifo_ptr_ctrl_pkg;

   localparam int FIFO_DATA_W = 8;
   localparam int FIFO_ADDR_W = 4;
   localparam int FIFO_PTR_W  = FIFO_ADDR_W + 1;
   localparam int FIFO_DEPTH  = 2 ** FIFO_ADDR_W;

   typedef logic [FIFO_PTR_W-1:0] ptr_t;

endpackage : fifo_ptr_ctrl_pkg

// File: rtl/fifo_ptr_cmp.sv
// fifo_ptr_cmp
// Combinational comparison of two wrap-bit pointers.
//   en      : in  compare enable; both flags are forced low when deasserted
//   ptr_a   : in  first pointer (write side)
//   ptr_b   : in  second pointer (read side)
//   eq      : out all bits equal (FIFO empty when applied to wr/rd pointers)
//   wrap_eq : out address bits equal but wrap bits differ (FIFO full)
module fifo_ptr_cmp
   import fifo_ptr_ctrl_pkg::*;
#(
   parameter int PTR_W = FIFO_PTR_W
) (
   input  logic             en,
   input  logic [PTR_W-1:0] ptr_a,
   input  logic [PTR_W-1:0] ptr_b,
   output logic             eq,
   output logic             wrap_eq
);

   // Same address with a different wrap bit means the writer is exactly one
   // full lap ahead of the reader.
   always_comb begin
      eq      = en && (ptr_a == ptr_b);
      wrap_eq = en && (ptr_a[PTR_W-2:0] == ptr_b[PTR_W-2:0])
                   && (ptr_a[PTR_W-1] != ptr_b[PTR_W-1]);
   end

endmodule : fifo_ptr_cmp

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl
// Synchronous FIFO stage with 2**ADDR_W words of storage. Owns the write and
// read pointers (address plus wrap bit), keeps registered full/empty/count and
// produces registered read data one cycle after an accepted read.
//   clk       : in  rising-edge clock
//   rst       : in  synchronous active-high reset
//   wr_en     : in  write request
//   wr_data   : in  write word
//   rd_en     : in  read request
//   rd_data   : out registered read word (holds when no read is accepted)
//   rd_valid  : out one-cycle strobe marking a newly read word on rd_data
//   full      : out FIFO holds 2**ADDR_W words
//   empty     : out FIFO holds no words
//   count     : out occupancy
//   wr_ptr    : out write pointer, exported to the comparator
//   rd_ptr    : out read pointer, exported to the comparator
// Optional macro FIFO_ERR_FLAGS_EN adds:
//   overflow  : out sticky, set by a write request while full
//   underflow : out sticky, set by a read request while empty
module fifo_ptr_ctrl
   import fifo_ptr_ctrl_pkg::*;
#(
   parameter int DATA_W = FIFO_DATA_W,
   parameter int ADDR_W = FIFO_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
`ifdef FIFO_ERR_FLAGS_EN
   output logic              overflow,
   output logic              underflow,
`endif
   output logic [ADDR_W:0]   wr_ptr,
   output logic [ADDR_W:0]   rd_ptr
);

   localparam int PTR_W = ADDR_W + 1;
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_acc, rd_acc;

`ifdef FIFO_ERR_FLAGS_EN
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
`endif

   // Acceptance uses the flags registered before the edge, so a full FIFO
   // still accepts a simultaneous read and an empty one a simultaneous write.
   always_comb begin
      wr_acc     = wr_en & ~full_q;
      rd_acc     = rd_en & ~empty_q;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d   = rd_ptr_q + PTR_W'(1);
         rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
         rd_valid_d = 1'b1;
      end

      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + PTR_W'(1);
         2'b01:   count_d = count_q - PTR_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Flags are derived from the next-state pointers so they are correct in
   // the same cycle the pointers land.
   fifo_ptr_cmp #(
      .PTR_W   (PTR_W)
   ) u_cmp (
      .en      (1'b1),
      .ptr_a   (wr_ptr_d),
      .ptr_b   (rd_ptr_d),
      .eq      (empty_d),
      .wrap_eq (full_d)
   );

`ifdef FIFO_ERR_FLAGS_EN
   // Sticky error flags see the raw requests, not the accepted ones.
   always_comb begin
      overflow_d  = overflow_q  | (wr_en & full_q);
      underflow_d = underflow_q | (rd_en & empty_q);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
`ifdef FIFO_ERR_FLAGS_EN
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
`endif
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
`ifdef FIFO_ERR_FLAGS_EN
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
`endif
      end
   end

   // Storage is deliberately left uncleared by reset; only the write is
   // suppressed while reset is asserted.
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
      end
   end

   assign wr_ptr   = wr_ptr_q;
   assign rd_ptr   = rd_ptr_q;
   assign count    = count_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
`ifdef FIFO_ERR_FLAGS_EN
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule : fifo_ptr_ctrl

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl
// Self-checking bench for fifo_ptr_ctrl: a vector table, hand-written corner
// sequences and a randomized phase, all compared against a queue-based model.
// Honours FIFO_ERR_FLAGS_EN for the optional overflow/underflow outputs.
module tb_fifo_ptr_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic [4:0] wr_ptr;
   logic [4:0] rd_ptr;
`ifdef FIFO_ERR_FLAGS_EN
   logic       overflow;
   logic       underflow;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: contents as a queue, pointers as running totals mod 32.
   logic [7:0] model_q [$];
   int         m_wr_tot;
   int         m_rd_tot;
   logic [7:0] m_rd_data;
   logic       m_rd_valid;
   logic       m_ovf;
   logic       m_udf;

   typedef struct {
      logic       rst;
      logic       wr_en;
      logic [7:0] wr_data;
      logic       rd_en;
      logic [4:0] exp_count;
      logic       exp_full;
      logic       exp_empty;
      logic       exp_valid;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs [11];

   fifo_ptr_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .full      (full),
      .empty     (empty),
      .count     (count),
`ifdef FIFO_ERR_FLAGS_EN
      .overflow  (overflow),
      .underflow (underflow),
`endif
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model step from the state the FIFO held before the edge.
   task automatic modelStep(input logic r, input logic w, input logic [7:0] d,
                            input logic rd);
      bit was_full;
      bit was_empty;
      was_full  = (model_q.size() == 16);
      was_empty = (model_q.size() == 0);
      if (r) begin
         model_q.delete();
         m_wr_tot   = 0;
         m_rd_tot   = 0;
         m_rd_data  = 8'h00;
         m_rd_valid = 1'b0;
         m_ovf      = 1'b0;
         m_udf      = 1'b0;
      end else begin
         if (w && was_full)  m_ovf = 1'b1;
         if (rd && was_empty) m_udf = 1'b1;
         if (rd && !was_empty) begin
            m_rd_data  = model_q.pop_front();
            m_rd_valid = 1'b1;
            m_rd_tot   = (m_rd_tot + 1) % 32;
         end else begin
            m_rd_valid = 1'b0;
         end
         if (w && !was_full) begin
            model_q.push_back(d);
            m_wr_tot = (m_wr_tot + 1) % 32;
         end
      end
   endtask

   task automatic checkModel();
      checkOutput("model_count", 32'(count), 32'(model_q.size()));
      checkOutput("model_full", 32'(full), 32'(model_q.size() == 16));
      checkOutput("model_empty", 32'(empty), 32'(model_q.size() == 0));
      checkOutput("model_wr_ptr", 32'(wr_ptr), 32'(m_wr_tot));
      checkOutput("model_rd_ptr", 32'(rd_ptr), 32'(m_rd_tot));
      checkOutput("model_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      checkOutput("model_rd_data", 32'(rd_data), 32'(m_rd_data));
`ifdef FIFO_ERR_FLAGS_EN
      checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("model_underflow", 32'(underflow), 32'(m_udf));
`endif
   endtask

   // Drive one cycle, advance to just after the edge, compare to the model.
   task automatic applyStimulus(input logic r, input logic w,
                                input logic [7:0] d, input logic rd);
      rst     = r;
      wr_en   = w;
      wr_data = d;
      rd_en   = rd;
      modelStep(r, w, d, rd);
      @(posedge clk);
      #1;
      checkModel();
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
   endtask

   initial begin
      logic [7:0] rnd;
      rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
      model_q.delete();
      m_wr_tot = 0; m_rd_tot = 0; m_rd_data = 8'h00; m_rd_valid = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0;

      //          rst   wr    data   rd    cnt full empty vld  data
      vecs[0]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b1, 8'hFF, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'hA1};
      vecs[5]  = '{1'b0, 1'b1, 8'hC3, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'hB2};
      vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'hB2};
      vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'hC3};
      vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 8'hC3};
      vecs[9]  = '{1'b0, 1'b1, 8'hD4, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'hC3};
      vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'hD4};

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
         checkOutput("vec_count", 32'(count), 32'(vecs[i].exp_count));
         checkOutput("vec_full", 32'(full), 32'(vecs[i].exp_full));
         checkOutput("vec_empty", 32'(empty), 32'(vecs[i].exp_empty));
         checkOutput("vec_rd_valid", 32'(rd_valid), 32'(vecs[i].exp_valid));
         checkOutput("vec_rd_data", 32'(rd_data), 32'(vecs[i].exp_data));
      end

      $display("[TB] reset with requests held");
      doReset();
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
      checkOutput("reset_empty", 32'(empty), 32'd1);
      checkOutput("reset_full", 32'(full), 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);
      checkOutput("reset_wr_ptr", 32'(wr_ptr), 32'd0);
      checkOutput("reset_rd_ptr", 32'(rd_ptr), 32'd0);
      checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);

      $display("[TB] fill and overflow");
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
      checkOutput("fill_count", 32'(count), 32'd16);
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_wr_ptr", 32'(wr_ptr), 32'b10000);
      checkOutput("fill_rd_ptr", 32'(rd_ptr), 32'd0);
      applyStimulus(1'b0, 1'b1, 8'hAA, 1'b0);
      checkOutput("ovf_wr_ptr", 32'(wr_ptr), 32'b10000);
      checkOutput("ovf_count", 32'(count), 32'd16);
`ifdef FIFO_ERR_FLAGS_EN
      checkOutput("ovf_flag", 32'(overflow), 32'd1);
`endif

      $display("[TB] drain and underflow");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
         checkOutput("drain_valid", 32'(rd_valid), 32'd1);
         checkOutput("drain_data", 32'(rd_data), 32'(i));
      end
      checkOutput("drain_empty", 32'(empty), 32'd1);
      checkOutput("drain_rd_ptr", 32'(rd_ptr), 32'b10000);
      checkOutput("drain_ptr_eq", 32'(rd_ptr), 32'(wr_ptr));
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("udf_valid", 32'(rd_valid), 32'd0);
      checkOutput("udf_rd_ptr", 32'(rd_ptr), 32'b10000);
`ifdef FIFO_ERR_FLAGS_EN
      checkOutput("udf_flag", 32'(underflow), 32'd1);
      doReset();
      checkOutput("err_clear_ovf", 32'(overflow), 32'd0);
      checkOutput("err_clear_udf", 32'(underflow), 32'd0);
`else
      doReset();
`endif

      $display("[TB] wrap rounds");
      for (int r = 1; r <= 3; r++) begin
         for (int i = 0; i < 16; i++) begin
            rnd = 8'($urandom_range(0, 255));
            applyStimulus(1'b0, 1'b1, rnd, 1'b0);
         end
         checkOutput("wrap_full", 32'(full), 32'd1);
         for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
         checkOutput("wrap_wr_ptr", 32'(wr_ptr), (r % 2 == 1) ? 32'd16 : 32'd0);
         checkOutput("wrap_rd_ptr", 32'(rd_ptr), (r % 2 == 1) ? 32'd16 : 32'd0);
      end

      $display("[TB] simultaneous requests");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b1, 8'h60 + 8'(i), 1'b1);
         checkOutput("sim5_count", 32'(count), 32'd5);
      end
      for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
      checkOutput("sim16_full_before", 32'(full), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'hEE, 1'b1);
      checkOutput("sim16_count", 32'(count), 32'd15);
      checkOutput("sim16_full", 32'(full), 32'd0);
      checkOutput("sim16_valid", 32'(rd_valid), 32'd1);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("sim0_empty_before", 32'(empty), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h33, 1'b1);
      checkOutput("sim0_count", 32'(count), 32'd1);
      checkOutput("sim0_valid", 32'(rd_valid), 32'd0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("sim0_data", 32'(rd_data), 32'h33);

      $display("[TB] reset mid-operation");
      for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'h90 + 8'(i), 1'b0);
      checkOutput("mid_count_before", 32'(count), 32'd9);
      applyStimulus(1'b1, 1'b1, 8'hFF, 1'b1);
      checkOutput("mid_count", 32'(count), 32'd0);
      checkOutput("mid_empty", 32'(empty), 32'd1);
      applyStimulus(1'b0, 1'b1, 8'h5A, 1'b0);
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
      checkOutput("mid_valid", 32'(rd_valid), 32'd1);
      checkOutput("mid_data", 32'(rd_data), 32'h5A);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         rnd = 8'($urandom_range(0, 255));
         applyStimulus(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                       rnd, 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_fifo_ptr_ctrl
